// File: rtl/bsram_stream_ctrl.sv
// bsram_stream_ctrl
// Burst initiator for a single-port BSRAM with a 1-cycle registered read.
//
// A command starts a write or read burst of cmd_len+1 consecutive words at
// cmd_base. Addresses wrap from DEPTH-1 to 0.
//   cmd_*      command handshake; cmd_ready is high only while idle
//   s_*        write stream sink; each accepted beat is written the same cycle
//   m_*        read stream source with full backpressure; m_last marks the
//              final word of the burst
//   busy/done  busy while a burst runs; done pulses the cycle after the
//              burst completes
//   mem_*      BSRAM port (ce/wre/addr/data_in/data_out)
module bsram_stream_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // rem_q: beats left minus one (writes) / pops left minus one (reads)
  logic [ADDR_W-1:0] rem_q, rem_d;
  // iss_q: read issues still to make; one bit wider to hold a full DEPTH burst
  logic [ADDR_W:0]   iss_q, iss_d;
  logic              done_q, done_d;

  // 2-entry read FIFO plus the in-flight word from last cycle's issue
  logic [DATA_W-1:0] fifo_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              infl_q;

  logic              wr_fire, issue, pop, push, fifo_pop;
  logic [2:0]        occ_after;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // When the FIFO is empty the in-flight word is presented straight from
  // mem_rdata, giving m_valid two cycles after command accept. If it is not
  // taken it lands in the FIFO, so m_data stays stable under backpressure.
  assign m_valid   = (cnt_q != 2'd0) || infl_q;
  assign m_data    = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : mem_rdata;
  assign pop       = m_valid && m_ready;
  assign fifo_pop  = pop && (cnt_q != 2'd0);
  assign push      = infl_q && !((cnt_q == 2'd0) && pop);

  // Words held or in flight after this cycle's pop must leave room for one more
  assign occ_after = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue     = (state_q == READ) && (iss_q != '0) && (occ_after < 3'd2);
  assign wr_fire   = (state_q == WRITE) && s_valid;

  assign cmd_ready = (state_q == IDLE);
  assign s_ready   = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign m_last    = m_valid && (state_q == READ) && (rem_q == '0);
  assign mem_ce    = wr_fire || issue;
  assign mem_wre   = wr_fire;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_fire ? s_data : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    iss_d   = iss_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_base;
          rem_d   = cmd_len;
          iss_d   = {1'b0, cmd_len} + (ADDR_W+1)'(1);
          state_d = cmd_rd ? READ : WRITE;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          addr_d = wrap_inc(addr_q);
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d = wrap_inc(addr_q);
          iss_d  = iss_q - (ADDR_W+1)'(1);
        end
        if (pop) begin
          rem_d = rem_q - ADDR_W'(1);
          if (rem_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, fifo_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      iss_q     <= '0;
      done_q    <= 1'b0;
      infl_q    <= 1'b0;
      cnt_q     <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      iss_q   <= iss_d;
      done_q  <= done_d;
      infl_q  <= issue;
      cnt_q   <= cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_bsram_stream_ctrl.sv
// tb_bsram_stream_ctrl
// Directed bench for bsram_stream_ctrl with a behavioural BSRAM (registered
// read) and a backdoor preload port on the memory model.
module tb_bsram_stream_ctrl;
  localparam int DW = 12;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0;
  logic [AW-1:0] cmd_base = '0, cmd_len = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0, m_last;
  logic [DW-1:0] m_data;
  logic          busy, done, mem_ce, mem_wre;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] bram [16384];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) bram[bd_addr] <= bd_data;
    else if (mem_ce) begin
      if (mem_wre) bram[mem_addr] <= mem_wdata;
      else         mem_rdata <= bram[mem_addr];
    end
  end

  bsram_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16384)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done),
    .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic preload(input logic [AW-1:0] base, input int n, input logic [DW-1:0] d0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = AW'(base + AW'(i)); bd_data = DW'(d0 + DW'(i));
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic send_cmd(input logic rd, input logic [AW-1:0] base, input logic [AW-1:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_base = base; cmd_len = len;
  endtask

  task automatic test_reset();
    logic [32:0] v;
    @(negedge clk); #1;
    v = {s_ready, m_valid, m_last, busy, done, mem_ce, mem_wre, mem_addr, mem_wdata};
    n_chk++; if (v !== 33'd0) begin n_fail++; $display("FAIL reset_outs: got %h exp 0", v); end
    rst = 1'b1; #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write();
    logic [29:0] v, e;
    send_cmd(1'b0, 14'h0010, 14'd3); #1;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready: got %b exp 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; s_valid = 1'b1; s_data = DW'(i + 1); #1;
      v = {mem_ce, mem_wre, mem_addr, mem_wdata, s_ready, done};
      e = {1'b1, 1'b1, AW'(16 + i), DW'(i + 1), 1'b1, 1'b0};
      n_chk++; if (v !== e) begin n_fail++; $display("FAIL wr_beat%0d: got %h exp %h", i, v, e); end
    end
    @(negedge clk); s_valid = 1'b0; #1;
    n_chk++; if ({done, busy, mem_ce} !== 3'b100) begin n_fail++; $display("FAIL wr_done: got %b exp 100", {done, busy, mem_ce}); end
    @(negedge clk); #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL wr_done_pulse: got %b exp 0", done); end
  endtask

  task automatic test_read_basic();
    logic [15:0] v, e;
    send_cmd(1'b1, 14'h0010, 14'd3);
    @(negedge clk); cmd_valid = 1'b0; m_ready = 1'b1; #1;
    v = {m_valid, mem_ce, mem_wre, mem_addr[12:0]};
    e = {1'b0, 1'b1, 1'b0, 13'h0010};
    n_chk++; if (v !== e) begin n_fail++; $display("FAIL rd_first_issue: got %h exp %h", v, e); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      v = {m_valid, m_last, mem_ce, m_data, 1'b0};
      e = {1'b1, (i == 3), (i < 3), DW'(i + 1), 1'b0};
      n_chk++; if (v !== e) begin n_fail++; $display("FAIL rd_word%0d: got %h exp %h", i, v, e); end
    end
    @(negedge clk); #1;
    n_chk++; if ({done, busy, m_valid} !== 3'b100) begin n_fail++; $display("FAIL rd_done: got %b exp 100", {done, busy, m_valid}); end
    @(negedge clk); m_ready = 1'b0; #1;
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rd_done_pulse: got %b exp 0", done); end
  endtask

  task automatic test_backpressure();
    logic [7:0]    pat = 8'h69;  // m_ready sequence 1,0,0,1,0,1,1,0
    int            idx = 0, issued = 0, dones = 0, maxout = 0;
    logic          stall_prev = 1'b0, fin = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic [AW-1:0] exp_iss = 14'h0100;
    preload(14'h0100, 8, 12'h300);
    send_cmd(1'b1, 14'h0100, 14'd7);
    for (int k = 0; k < 80 && !fin; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0; m_ready = pat[k % 8]; #1;
      if (stall_prev) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_data !== data_prev) begin
          n_fail++; $display("FAIL bp_stable: got %b/%h exp 1/%h", m_valid, m_data, data_prev);
        end
      end
      if (mem_ce === 1'b1) begin
        n_chk++;
        if (mem_wre !== 1'b0 || mem_addr !== exp_iss) begin
          n_fail++; $display("FAIL bp_issue: got %b/%h exp 0/%h", mem_wre, mem_addr, exp_iss);
        end
        exp_iss = exp_iss + 14'd1; issued++;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        n_chk++;
        if (m_data !== DW'(12'h300 + DW'(idx)) || m_last !== (idx == 7)) begin
          n_fail++; $display("FAIL bp_word%0d: got %h/%b exp %h/%b", idx, m_data, m_last, 12'h300 + DW'(idx), idx == 7);
        end
        idx++;
      end
      if (issued - idx > maxout) maxout = issued - idx;
      stall_prev = m_valid && !m_ready;
      data_prev = m_data;
      if (done === 1'b1) begin dones++; fin = 1'b1; end
    end
    @(negedge clk); m_ready = 1'b0; #1;
    if (done === 1'b1) dones++;
    n_chk++; if (idx != 8 || issued != 8) begin n_fail++; $display("FAIL bp_count: got %0d/%0d exp 8/8", idx, issued); end
    n_chk++; if (maxout > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d exp <=2", maxout); end
    n_chk++; if (dones != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_done: got %0d/%b exp 1/0", dones, busy); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    send_cmd(1'b0, 14'h3FFE, 14'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; s_valid = 1'b1; s_data = DW'(12'hA00 + DW'(i)); #1;
      a = AW'(14'h3FFE + AW'(i));
      n_chk++; if (mem_addr !== a || mem_ce !== 1'b1) begin n_fail++; $display("FAIL wrap_waddr%0d: got %h exp %h", i, mem_addr, a); end
    end
    @(negedge clk); s_valid = 1'b0; #1;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_wdone: got %b exp 1", done); end
    n_chk++;
    if (bram[14'h3FFE] !== 12'hA00 || bram[14'h3FFF] !== 12'hA01 || bram[14'h0000] !== 12'hA02 || bram[14'h0001] !== 12'hA03) begin
      n_fail++; $display("FAIL wrap_mem: got %h %h %h %h exp a00 a01 a02 a03", bram[14'h3FFE], bram[14'h3FFF], bram[14'h0000], bram[14'h0001]);
    end
    send_cmd(1'b1, 14'h3FFE, 14'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cmd_valid = 1'b0; m_ready = 1'b1; #1;
      if (i < 4) begin
        a = AW'(14'h3FFE + AW'(i));
        n_chk++; if (mem_addr !== a || mem_ce !== 1'b1) begin n_fail++; $display("FAIL wrap_raddr%0d: got %h exp %h", i, mem_addr, a); end
      end
      if (i > 0) begin
        n_chk++;
        if (m_valid !== 1'b1 || m_data !== DW'(12'hA00 + DW'(i - 1)) || m_last !== (i == 4)) begin
          n_fail++; $display("FAIL wrap_rword%0d: got %b/%h/%b exp 1/%h/%b", i - 1, m_valid, m_data, m_last, 12'hA00 + DW'(i - 1), i == 4);
        end
      end
    end
    @(negedge clk); m_ready = 1'b0; #1;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_rdone: got %b exp 1", done); end
  endtask

  task automatic test_len0_busy_cmd();
    send_cmd(1'b0, 14'h0040, 14'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_base = 14'h0099; s_valid = 1'b0; #1;
      n_chk++; if ({cmd_ready, busy, mem_ce} !== 3'b010) begin n_fail++; $display("FAIL busy_cmd%0d: got %b exp 010", i, {cmd_ready, busy, mem_ce}); end
    end
    @(negedge clk); cmd_valid = 1'b0; s_valid = 1'b1; s_data = 12'h5A5; #1;
    n_chk++; if ({mem_ce, mem_wre, mem_addr, mem_wdata} !== {1'b1, 1'b1, 14'h0040, 12'h5A5}) begin
      n_fail++; $display("FAIL len0_write: got %b%b/%h/%h exp 11/0040/5a5", mem_ce, mem_wre, mem_addr, mem_wdata);
    end
    @(negedge clk); s_valid = 1'b0; #1;
    n_chk++; if ({done, busy, mem_ce} !== 3'b100) begin n_fail++; $display("FAIL len0_wdone: got %b exp 100", {done, busy, mem_ce}); end
    send_cmd(1'b1, 14'h0040, 14'd0);
    @(negedge clk); cmd_valid = 1'b0; m_ready = 1'b1; #1;
    n_chk++; if ({mem_ce, mem_wre, mem_addr, m_valid} !== {1'b1, 1'b0, 14'h0040, 1'b0}) begin
      n_fail++; $display("FAIL len0_issue: got %b%b/%h/%b exp 10/0040/0", mem_ce, mem_wre, mem_addr, m_valid);
    end
    @(negedge clk); #1;
    n_chk++; if ({m_valid, m_last, mem_ce, m_data} !== {3'b110, 12'h5A5}) begin
      n_fail++; $display("FAIL len0_word: got %b%b%b/%h exp 110/5a5", m_valid, m_last, mem_ce, m_data);
    end
    @(negedge clk); m_ready = 1'b0; #1;
    n_chk++; if ({done, busy} !== 2'b10) begin n_fail++; $display("FAIL len0_rdone: got %b exp 10", {done, busy}); end
  endtask

  task automatic test_reset_mid_read();
    logic [32:0] v;
    preload(14'h0200, 2, 12'h7A0);
    send_cmd(1'b1, 14'h0100, 14'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cmd_valid = 1'b0; m_ready = 1'b1;
    end
    #1;
    n_chk++; if (m_data !== 12'h301) begin n_fail++; $display("FAIL rst_pre_word: got %h exp 301", m_data); end
    @(negedge clk); #2 rst = 1'b0; #1;
    v = {s_ready, m_valid, m_last, busy, done, mem_ce, mem_wre, mem_addr, mem_wdata};
    n_chk++; if (v !== 33'd0) begin n_fail++; $display("FAIL rst_async: got %h exp 0", v); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_chk++; if ({done, busy, m_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_hold%0d: got %b exp 000", i, {done, busy, m_valid}); end
    end
    @(negedge clk); rst = 1'b1; #1;
    n_chk++; if ({cmd_ready, done} !== 2'b10) begin n_fail++; $display("FAIL rst_release: got %b exp 10", {cmd_ready, done}); end
    send_cmd(1'b1, 14'h0200, 14'd1);
    @(negedge clk); cmd_valid = 1'b0; #1;
    n_chk++; if (mem_addr !== 14'h0200 || mem_ce !== 1'b1) begin n_fail++; $display("FAIL rst_new_issue: got %h exp 0200", mem_addr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_chk++; if ({m_valid, m_last, m_data} !== {1'b1, (i == 1), DW'(12'h7A0 + DW'(i))}) begin
        n_fail++; $display("FAIL rst_new_word%0d: got %b%b/%h exp 1%b/%h", i, m_valid, m_last, m_data, i == 1, 12'h7A0 + DW'(i));
      end
    end
    @(negedge clk); m_ready = 1'b0; #1;
    n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_new_done: got %b exp 1", done); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_basic();
    test_backpressure();
    test_wrap();
    test_len0_busy_cmd();
    test_reset_mid_read();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
